// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller signals of the SDRAM port arbiter, bundled as one interface.
// slave is the arbiter's view; master is the surrounding logic (requesters plus controller).
interface sdram_port_arbiter_if #(
   parameter int unsigned ADDR_W = 22,
   parameter int unsigned DATA_W = 16
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              mc_busy;
   logic              mc_rd_ready;
   logic [DATA_W-1:0] mc_rd_data;
   logic              mc_wr_done;
   logic              mc_rd_enable;
   logic              mc_wr_enable;
   logic [ADDR_W-1:0] mc_addr;
   logic [DATA_W-1:0] mc_wr_data;
   logic [1:0]        owner;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  mc_busy, mc_rd_ready, mc_rd_data, mc_wr_done,
      output rd_ack, rd_data, wr_ack,
      output mc_rd_enable, mc_wr_enable, mc_addr, mc_wr_data, owner
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output mc_busy, mc_rd_ready, mc_rd_data, mc_wr_done,
      input  rd_ack, rd_data, wr_ack,
      input  mc_rd_enable, mc_wr_enable, mc_addr, mc_wr_data, owner
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the display read path and the user write path.
// Define RD_STARVE_GUARD_EN to bound consecutive read grants while a write is waiting.
module sdram_port_arbiter #(
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RD_RUN_MAX = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   sdram_port_arbiter_if.slave io_bus
);
   typedef enum logic [2:0] {
      StIdle,
      StRdIssue,
      StRdWait,
      StWrIssue,
      StWrWait
   } state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_rd_grant;
   logic              w_wr_grant;
   logic              w_rd_ack;
   logic              w_wr_ack;
   logic              w_rd_en;
   logic              w_wr_en;
   logic [1:0]        w_owner;
   logic              w_force_wr;

`ifdef RD_STARVE_GUARD_EN
   localparam logic [3:0] RunMax = 4'(RD_RUN_MAX);

   logic [3:0] r_run_cnt;

   // Counts read grants taken while a write is pending; saturates rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_run_cnt <= '0;
      end else if (!io_bus.wr_req || w_wr_grant) begin
         r_run_cnt <= '0;
      end else if (w_rd_grant && (r_run_cnt != 4'hF)) begin
         r_run_cnt <= r_run_cnt + 4'd1;
      end
   end

   assign w_force_wr = (r_run_cnt >= RunMax);
`else
   logic w_unused_run_max;

   assign w_force_wr       = 1'b0;
   assign w_unused_run_max = |RD_RUN_MAX;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_rd_grant = 1'b0;
      w_wr_grant = 1'b0;
      w_rd_ack   = 1'b0;
      w_wr_ack   = 1'b0;
      w_rd_en    = 1'b0;
      w_wr_en    = 1'b0;
      w_owner    = 2'b00;
      unique case (r_state)
         StIdle: begin
            if (!io_bus.mc_busy) begin
               if (io_bus.wr_req && (w_force_wr || !io_bus.rd_req)) begin
                  w_wr_grant = 1'b1;
                  w_state_d  = StWrIssue;
               end else if (io_bus.rd_req) begin
                  w_rd_grant = 1'b1;
                  w_state_d  = StRdIssue;
               end
            end
         end
         StRdIssue: begin
            w_rd_en   = 1'b1;
            w_owner   = 2'b01;
            w_state_d = StRdWait;
         end
         StRdWait: begin
            w_owner = 2'b01;
            if (io_bus.mc_rd_ready) begin
               w_rd_ack  = 1'b1;
               w_state_d = StIdle;
            end
         end
         StWrIssue: begin
            w_wr_en   = 1'b1;
            w_owner   = 2'b10;
            w_state_d = StWrWait;
         end
         StWrWait: begin
            w_owner = 2'b10;
            if (io_bus.mc_wr_done) begin
               w_wr_ack  = 1'b1;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Address and write data are captured on the grant so requester changes after it are ignored.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr    <= '0;
         r_wr_data <= '0;
      end else if (w_rd_grant) begin
         r_addr <= io_bus.rd_addr;
      end else if (w_wr_grant) begin
         r_addr    <= io_bus.wr_addr;
         r_wr_data <= io_bus.wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (w_rd_ack) begin
         r_rd_data <= io_bus.mc_rd_data;
      end
   end

   // Bypass the capture register in the ack cycle so rd_data is valid alongside rd_ack.
   assign io_bus.rd_data      = w_rd_ack ? io_bus.mc_rd_data : r_rd_data;
   assign io_bus.rd_ack       = w_rd_ack;
   assign io_bus.wr_ack       = w_wr_ack;
   assign io_bus.mc_rd_enable = w_rd_en;
   assign io_bus.mc_wr_enable = w_wr_en;
   assign io_bus.mc_addr      = r_addr;
   assign io_bus.mc_wr_data   = r_wr_data;
   assign io_bus.owner        = w_owner;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a small controller model answers commands and a
// negedge monitor pops expected grants / read data as the arbiter produces them.
module tb_sdram_port_arbiter;
   localparam int unsigned AW = 22;
   localparam int unsigned DW = 16;
`ifdef RD_STARVE_GUARD_EN
   localparam bit GuardEn = 1'b1;
`else
   localparam bit GuardEn = 1'b0;
`endif

   typedef struct {
      bit          is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } grant_t;

   logic clk;
   logic rst_n;

   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sdram_port_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .RD_RUN_MAX(8)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (bus)
   );

   grant_t        exp_grant_q[$];
   logic [DW-1:0] exp_rdata_q[$];
   int n_vec    = 0;
   int n_err    = 0;
   int n_grants = 0;
   int n_rd_ack = 0;
   int n_wr_ack = 0;
   int lat      = 2;
   int rd_cnt   = 0;
   int wr_cnt   = 0;
   logic [AW-1:0] model_rd_addr;
   grant_t        mon_g;
   logic [DW-1:0] mon_d;

   function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hDB5A;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model: strobes ready/done `lat` cycles after seeing a command.
   always @(posedge clk) begin
      #1;
      bus.mc_rd_ready = 1'b0;
      bus.mc_wr_done  = 1'b0;
      bus.mc_rd_data  = 16'hDEAD;
      if (rd_cnt == 1) begin
         bus.mc_rd_ready = 1'b1;
         bus.mc_rd_data  = rd_pattern(model_rd_addr);
      end
      if (rd_cnt != 0) rd_cnt--;
      if (wr_cnt == 1) bus.mc_wr_done = 1'b1;
      if (wr_cnt != 0) wr_cnt--;
      if (bus.mc_rd_enable) begin
         rd_cnt        = lat;
         model_rd_addr = bus.mc_addr;
      end
      if (bus.mc_wr_enable) wr_cnt = lat;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mc_rd_enable || bus.mc_wr_enable) begin
            n_grants++;
            n_vec++;
            if (bus.mc_rd_enable && bus.mc_wr_enable) begin
               n_err++;
               $display("FAIL grant_exclusive: both enables high, required at most one");
            end else if (exp_grant_q.size() == 0) begin
               n_err++;
               $display("FAIL grant_unexpected: got wr=%0b addr=%h, required no grant",
                        bus.mc_wr_enable, bus.mc_addr);
            end else begin
               mon_g = exp_grant_q.pop_front();
               if (bus.mc_wr_enable !== mon_g.is_wr || bus.mc_addr !== mon_g.addr ||
                   (mon_g.is_wr && bus.mc_wr_data !== mon_g.data)) begin
                  n_err++;
                  $display("FAIL grant_content: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                           bus.mc_wr_enable, bus.mc_addr, bus.mc_wr_data,
                           mon_g.is_wr, mon_g.addr, mon_g.data);
               end
            end
         end
         if (bus.rd_ack) begin
            n_rd_ack++;
            n_vec++;
            if (exp_rdata_q.size() == 0) begin
               n_err++;
               $display("FAIL rd_ack_unexpected: got rd_ack data=%h, required no ack", bus.rd_data);
            end else begin
               mon_d = exp_rdata_q.pop_front();
               if (bus.rd_data !== mon_d) begin
                  n_err++;
                  $display("FAIL rd_data: got %h, required %h", bus.rd_data, mon_d);
               end
            end
         end
         if (bus.wr_ack) n_wr_ack++;
      end
   end

   task automatic push_rd(input logic [AW-1:0] a);
      exp_grant_q.push_back('{is_wr: 1'b0, addr: a, data: '0});
      exp_rdata_q.push_back(rd_pattern(a));
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_grant_q.push_back('{is_wr: 1'b1, addr: a, data: d});
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (exp_grant_q.size() == 0 && exp_rdata_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [59:0] obs;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      obs = {bus.rd_ack, bus.wr_ack, bus.mc_rd_enable, bus.mc_wr_enable, bus.owner,
             bus.rd_data, bus.mc_addr, bus.mc_wr_data};
      n_vec++;
      if (obs !== 60'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h, required 0", obs);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read;
      bit ok;
      int en0;
      en0 = n_grants;
      bus.rd_addr = 22'h12345;
      bus.rd_req  = 1'b1;
      push_rd(22'h12345);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.rd_ack) begin
            ok = 1'b1;
            break;
         end
      end
      bus.rd_req = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL read_ack_timeout: got no rd_ack in 50 cycles, required one");
      end
      n_vec++;
      if (bus.rd_data !== 16'hF81F || bus.owner !== 2'b01) begin
         n_err++;
         $display("FAIL read_ack_cycle: got data=%h owner=%b, required F81F 01", bus.rd_data, bus.owner);
      end
      @(negedge clk);
      n_vec++;
      if (bus.rd_ack !== 1'b0 || bus.rd_data !== 16'hF81F) begin
         n_err++;
         $display("FAIL read_hold: got ack=%b data=%h, required 0 F81F", bus.rd_ack, bus.rd_data);
      end
      n_vec++;
      if (n_grants - en0 !== 1) begin
         n_err++;
         $display("FAIL read_enable_cycles: got %0d, required 1", n_grants - en0);
      end
      drain(ok);
   endtask

   task automatic test_write;
      bit ok;
      int wa0;
      wa0 = n_wr_ack;
      bus.wr_addr = 22'h00010;
      bus.wr_data = 16'h07E0;
      bus.wr_req  = 1'b1;
      push_wr(22'h00010, 16'h07E0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.mc_wr_enable) begin
            ok = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!ok || bus.mc_wr_data !== 16'h07E0) begin
         n_err++;
         $display("FAIL write_issue: got en=%b data=%h, required 1 07E0", ok, bus.mc_wr_data);
      end
      // Requester changes its mind after the grant; the latched access must still finish.
      bus.wr_data = 16'hFFFF;
      bus.wr_addr = 22'h3FFFFF;
      bus.wr_req  = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.wr_ack) begin
            ok = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!ok || bus.owner !== 2'b10 || bus.mc_wr_data !== 16'h07E0 || bus.mc_addr !== 22'h10) begin
         n_err++;
         $display("FAIL write_ack: got ack=%b owner=%b data=%h addr=%h, required 1 10 07E0 000010",
                  ok, bus.owner, bus.mc_wr_data, bus.mc_addr);
      end
      @(negedge clk);
      n_vec++;
      if (bus.wr_ack !== 1'b0 || bus.owner !== 2'b00) begin
         n_err++;
         $display("FAIL write_after_ack: got ack=%b owner=%b, required 0 00", bus.wr_ack, bus.owner);
      end
      drain(ok);
      n_vec++;
      if (n_wr_ack - wa0 !== 1) begin
         n_err++;
         $display("FAIL write_ack_count: got %0d, required 1", n_wr_ack - wa0);
      end
   endtask

   task automatic test_both_same_cycle;
      bit ok;
      push_rd(22'h0ABCD);
      push_wr(22'h15555, 16'hF00F);
      bus.rd_addr = 22'h0ABCD;
      bus.wr_addr = 22'h15555;
      bus.wr_data = 16'hF00F;
      bus.rd_req  = 1'b1;
      bus.wr_req  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.rd_ack) begin
            ok = 1'b1;
            break;
         end
      end
      bus.rd_req = 1'b0;
      n_vec++;
      if (!ok || exp_grant_q.size() !== 1) begin
         n_err++;
         $display("FAIL both_read_first: got ack=%b pending=%0d, required 1 1", ok, exp_grant_q.size());
      end
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.wr_ack) begin
            ok = 1'b1;
            break;
         end
      end
      bus.wr_req = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL both_write_after: got no wr_ack, required one");
      end
      drain(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL both_drain: got %0d pending, required 0", exp_grant_q.size());
      end
   endtask

   task automatic test_busy;
      bit ok;
      int g0;
      bus.mc_busy = 1'b1;
      bus.rd_addr = 22'h2AAAA;
      bus.rd_req  = 1'b1;
      push_rd(22'h2AAAA);
      g0 = n_grants;
      repeat (20) @(negedge clk);
      n_vec++;
      if (n_grants != g0 || bus.owner !== 2'b00) begin
         n_err++;
         $display("FAIL busy_hold: got grants=%0d owner=%b, required 0 00", n_grants - g0, bus.owner);
      end
      bus.mc_busy = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.mc_rd_enable !== 1'b1) begin
         n_err++;
         $display("FAIL busy_release: got mc_rd_enable=%b, required 1", bus.mc_rd_enable);
      end
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.rd_ack) begin
            ok = 1'b1;
            break;
         end
      end
      bus.rd_req = 1'b0;
      drain(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL busy_drain: got %0d pending, required 0", exp_grant_q.size());
      end
   endtask

   task automatic test_starve;
      bit ok;
      int g0, wa0, exp_wr;
      exp_wr = 0;
      for (int i = 0; i < 18; i++) begin
         if (GuardEn && (i % 9 == 8)) begin
            push_wr(22'h00200, 16'h1234);
            exp_wr++;
         end else begin
            push_rd(22'h00100);
         end
      end
      g0  = n_grants;
      wa0 = n_wr_ack;
      bus.rd_addr = 22'h00100;
      bus.wr_addr = 22'h00200;
      bus.wr_data = 16'h1234;
      bus.rd_req  = 1'b1;
      bus.wr_req  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (n_grants - g0 >= 18) begin
            ok = 1'b1;
            break;
         end
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL starve_timeout: got %0d grants, required 18", n_grants - g0);
      end
      drain(ok);
      n_vec++;
      if (!ok || n_wr_ack - wa0 !== exp_wr) begin
         n_err++;
         $display("FAIL starve_writes: got wr_acks=%0d pending=%0d, required %0d 0",
                  n_wr_ack - wa0, exp_grant_q.size(), exp_wr);
      end
   endtask

   task automatic test_reset_mid_read;
      bit ok;
      int a0;
      logic [59:0] obs;
      lat = 6;
      bus.rd_addr = 22'h3C3C3;
      bus.rd_req  = 1'b1;
      push_rd(22'h3C3C3);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.mc_rd_enable) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      rst_n       = 1'b0;
      bus.rd_req  = 1'b0;
      exp_rdata_q.delete();
      #1;
      obs = {bus.rd_ack, bus.wr_ack, bus.mc_rd_enable, bus.mc_wr_enable, bus.owner,
             bus.rd_data, bus.mc_addr, bus.mc_wr_data};
      n_vec++;
      if (!ok || obs !== 60'h0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got issued=%b outputs=%h, required 1 0", ok, obs);
      end
      a0 = n_rd_ack;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      n_vec++;
      if (n_rd_ack != a0 || bus.owner !== 2'b00) begin
         n_err++;
         $display("FAIL reset_mid_no_ack: got acks=%0d owner=%b, required 0 00", n_rd_ack - a0, bus.owner);
      end
      lat = 2;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.rd_req  = 1'b0;
      bus.rd_addr = '0;
      bus.wr_req  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.mc_busy = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_both_same_cycle();
      test_busy();
      test_starve();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
